// File: rtl/sum_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and default widths.
package sum_pkg;

    localparam int SUM_WIDTH = 4;
    localparam int SUM_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mod_sum.sv
// Unsigned ripple-carry adder; cout is the carry out of the most significant bit.
module mod_sum #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The carry travels through a procedural variable so the chain stays a flat
    // combinational ripple rather than a self-referencing vector.
    always_comb begin
        logic c;
        c    = 1'b0;
        sum  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/sum_accum.sv
// Handshaked unsigned accumulator with sticky carry and saturating operand count.
//   state | meaning
//   IDLE  | waiting for start, last result held on the outputs
//   ACCUM | accepting operands, adding each into the accumulator
//   DONE  | one-cycle completion pulse after the in_last operand
module sum_accum
    import sum_pkg::*;
#(
    parameter int WIDTH = SUM_WIDTH,
    parameter int CNT_W = SUM_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry_out,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WIDTH-1:0]   sum_w;
    logic               cout_w;
    logic               handshake;

    mod_sum #(
        .WIDTH (WIDTH)
    ) u_mod_sum (
        .a    (acc_q),
        .b    (in_data),
        .sum  (sum_w),
        .cout (cout_w)
    );

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q == ACCUM);
    assign done      = (state_q == DONE);
    assign handshake = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                // A restart wins over an operand presented in the same cycle.
                if (start) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                end else if (handshake) begin
                    acc_d   = sum_w;
                    carry_d = carry_q | cout_w;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (start) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    assign acc_out   = acc_q;
    assign carry_out = carry_q;
    assign count     = count_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed and random checks of sum_accum against an arithmetic reference model.
module tb_sum_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_last;

    logic       in_ready, carry_out, busy, done;
    logic [3:0] acc_out;
    logic [3:0] count;

    logic       s_in_ready, s_carry_out, s_busy, s_done;
    logic [3:0] s_acc_out;
    logic [1:0] s_count;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: phase 0 idle, 1 accumulating, 2 completion pulse
    int m_phase;
    int m_acc;
    int m_carry;
    int m_cnt;
    int m_cnt_sat;

    sum_accum #(.WIDTH(4), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .carry_out (carry_out),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    sum_accum #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (s_in_ready),
        .acc_out   (s_acc_out),
        .carry_out (s_carry_out),
        .count     (s_count),
        .busy      (s_busy),
        .done      (s_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_acc     = 0;
        m_carry   = 0;
        m_cnt     = 0;
        m_cnt_sat = 0;
    endtask

    task automatic model_clear();
        m_acc     = 0;
        m_carry   = 0;
        m_cnt     = 0;
        m_cnt_sat = 0;
    endtask

    task automatic model_edge(input logic s, input logic v, input logic [3:0] d, input logic l);
        int t;
        case (m_phase)
            0: begin
                if (s) begin
                    model_clear();
                    m_phase = 1;
                end
            end
            1: begin
                if (s) begin
                    model_clear();
                end else if (v) begin
                    t = m_acc + int'(d);
                    if (t > 15) m_carry = 1;
                    m_acc = t % 16;
                    if (m_cnt < 15) m_cnt++;
                    if (m_cnt_sat < 3) m_cnt_sat++;
                    if (l) m_phase = 2;
                end
            end
            default: begin
                if (s) begin
                    model_clear();
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".acc"},     32'(acc_out),     32'(m_acc));
        chk({ph, ".carry"},   32'(carry_out),   32'(m_carry));
        chk({ph, ".count"},   32'(count),       32'(m_cnt));
        chk({ph, ".ready"},   32'(in_ready),    32'(m_phase == 1));
        chk({ph, ".busy"},    32'(busy),        32'(m_phase == 1));
        chk({ph, ".done"},    32'(done),        32'(m_phase == 2));
        chk({ph, ".s_acc"},   32'(s_acc_out),   32'(m_acc));
        chk({ph, ".s_carry"}, 32'(s_carry_out), 32'(m_carry));
        chk({ph, ".s_count"}, 32'(s_count),     32'(m_cnt_sat));
        chk({ph, ".s_ready"}, 32'(s_in_ready),  32'(m_phase == 1));
        chk({ph, ".s_busy"},  32'(s_busy),      32'(m_phase == 1));
        chk({ph, ".s_done"},  32'(s_done),      32'(m_phase == 2));
    endtask

    task automatic cyc(input string ph, input logic s, input logic v, input logic [3:0] d,
                       input logic l);
        @(negedge clk);
        start    = s;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        model_edge(s, v, d, l);
        #1;
        check_all(ph);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        in_last  = 1'b0;
        model_reset();
        #12;
        check_all("reset");

        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_reset", 0, 0, 0, 0);
        cyc("post_reset", 0, 1, 4'd6, 1);

        // normal sum 3+5+2
        cyc("norm", 1, 0, 0, 0);
        cyc("norm", 0, 1, 4'd3, 0);
        cyc("norm", 0, 1, 4'd5, 0);
        cyc("norm", 0, 1, 4'd2, 1);
        chk("norm.acc10",  32'(acc_out),   32'd10);
        chk("norm.cnt3",   32'(count),     32'd3);
        chk("norm.carry0", 32'(carry_out), 32'd0);
        chk("norm.done1",  32'(done),      32'd1);
        cyc("norm_after", 0, 0, 0, 0);
        chk("norm.done0",  32'(done),      32'd0);
        chk("norm.hold",   32'(acc_out),   32'd10);

        // operand offered while idle is ignored
        cyc("idle_bp", 0, 1, 4'd7, 1);
        chk("idle_bp.ready", 32'(in_ready), 32'd0);
        chk("idle_bp.acc",   32'(acc_out),  32'd10);

        // overflow 9+8
        cyc("ovf", 1, 0, 0, 0);
        cyc("ovf", 0, 1, 4'd9, 0);
        cyc("ovf", 0, 1, 4'd8, 1);
        chk("ovf.acc1",   32'(acc_out),   32'd1);
        chk("ovf.carry1", 32'(carry_out), 32'd1);
        cyc("ovf_after", 0, 0, 0, 0);

        // sticky carry 15+1+0
        cyc("sticky", 1, 0, 0, 0);
        cyc("sticky", 0, 1, 4'd15, 0);
        chk("sticky.carry0", 32'(carry_out), 32'd0);
        cyc("sticky", 0, 1, 4'd1, 0);
        cyc("sticky", 0, 1, 4'd0, 1);
        chk("sticky.acc0",   32'(acc_out),   32'd0);
        chk("sticky.carry1", 32'(carry_out), 32'd1);
        cyc("sticky_after", 0, 0, 0, 0);

        // gap of in_valid=0 while accumulating
        cyc("gap", 1, 0, 0, 0);
        cyc("gap", 0, 1, 4'd2, 0);
        for (int i = 0; i < 3; i++) cyc("gap_hold", 0, 0, 4'd9, 1);
        chk("gap.acc2",  32'(acc_out), 32'd2);
        chk("gap.cnt1",  32'(count),   32'd1);
        chk("gap.busy",  32'(busy),    32'd1);
        cyc("gap", 0, 1, 4'd3, 1);
        chk("gap.acc5",  32'(acc_out), 32'd5);
        cyc("gap_after", 0, 0, 0, 0);

        // restart overrides a same-cycle operand
        cyc("restart", 1, 0, 0, 0);
        cyc("restart", 0, 1, 4'd4, 0);
        cyc("restart", 0, 1, 4'd6, 0);
        cyc("restart", 1, 1, 4'd9, 0);
        chk("restart.acc0", 32'(acc_out), 32'd0);
        chk("restart.cnt0", 32'(count),   32'd0);
        chk("restart.busy", 32'(busy),    32'd1);
        cyc("restart", 0, 1, 4'd1, 1);
        cyc("restart_after", 0, 0, 0, 0);

        // count saturation with five operands of 1
        cyc("sat", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc("sat", 0, 1, 4'd1, 0);
        cyc("sat", 0, 1, 4'd1, 1);
        chk("sat.s_cnt3", 32'(s_count),   32'd3);
        chk("sat.s_acc5", 32'(s_acc_out), 32'd5);
        chk("sat.cnt5",   32'(count),     32'd5);
        cyc("sat_after", 0, 0, 0, 0);

        // asynchronous reset in the middle of a sum
        cyc("rst_mid", 1, 0, 0, 0);
        cyc("rst_mid", 0, 1, 4'd5, 0);
        cyc("rst_mid", 0, 1, 4'd5, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_async.acc0", 32'(acc_out), 32'd0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_after", 0, 0, 0, 0);
        chk("rst_after.done0", 32'(done), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)),
                1'($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter WIDTH, default 4: width of operand and accumulator.
REQ-002 Parameter CNT_W, default 4: width of the accepted-operand counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request: clear the accumulator and begin a new sum.
REQ-006 in_data  input  WIDTH  operand to add.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_last  input  1  qualifies in_data as the final operand of the sum.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 acc_out  output  WIDTH  current accumulated sum, modulo 2^WIDTH.
REQ-011 carry_out  output  1  sticky flag: a carry-out occurred on some addition since the last clear.
REQ-012 count  output  CNT_W  number of operands accepted since the last clear, saturating.
REQ-013 busy  output  1  high while in ACCUM.
REQ-014 done  output  1  one-cycle pulse marking completion of a sum.

Function
REQ-015 FSM states: IDLE, ACCUM, DONE.
REQ-016 IDLE: in_ready=0, busy=0; start=1 -> clear acc_out, carry_out, count; next state ACCUM.
REQ-017 ACCUM: in_ready=1, busy=1; handshake = in_valid & in_ready.
REQ-018 On handshake: acc_out <= sum(acc_out, in_data); carry_out <= carry_out | cout; count <= count+1, held at all-ones when saturated.
REQ-019 Handshake with in_last=1 -> next state DONE; otherwise remain in ACCUM.
REQ-020 The updated acc_out, carry_out and count are visible on the cycle after the handshake (latency 1).
REQ-021 in_valid=0 in ACCUM: all registers hold their values.
REQ-022 start=1 in ACCUM overrides any same-cycle handshake: the operand is discarded, the accumulator is cleared, and the state remains ACCUM.
REQ-023 DONE: done=1 for exactly one cycle, in_ready=0, results held; next state IDLE, or ACCUM with a clear if start=1.
REQ-024 In IDLE, acc_out, carry_out and count hold the last result until the next start.
REQ-025 in_data, in_valid and in_last are ignored whenever in_ready=0.
REQ-026 Addition is unsigned; sum is the low WIDTH bits; cout is the bit-WIDTH carry.

Reset
REQ-027 rst_n=0 immediately forces the following, regardless of clk: state IDLE, acc_out=0, carry_out=0, count=0, in_ready=0, busy=0, done=0.
REQ-028 Reset asserted mid-sum discards the partial sum; no done pulse follows.
REQ-029 After reset release, the block stays in IDLE until start.

Structure
REQ-030 Shared package sum_pkg holds the FSM state enum (IDLE, ACCUM, DONE) and the default WIDTH constant.
REQ-031 The adder datapath is one instance of the existing ripple-carry adder mod_sum, with operands acc_out and in_data, consuming its sum and cout.
REQ-032 The carry taken from mod_sum is the MSB carry for any WIDTH, not a fixed bit index.

Verification
REQ-033 Normal sum: start; operands 3, 5, 2 (in_last on 2) -> acc_out=10, carry_out=0, count=3, one done pulse, one cycle after the last handshake.
REQ-034 Overflow: start; 9, then 8 with in_last -> acc_out=1, carry_out=1; sticky case 15, 1, 0 (in_last) -> acc_out=0, carry_out stays 1.
REQ-035 Backpressure: in_valid=1 with in_data=7 while in IDLE -> in_ready=0, acc_out unchanged; a gap of in_valid=0 in ACCUM leaves registers held.
REQ-036 Restart: start; 4, 6, then start together with in_valid=1 and in_data=9 -> acc_out=0, count=0, state ACCUM, operand 9 dropped.
REQ-037 Reset mid-sum: start; 5, 5, then rst_n low asynchronously -> all outputs 0 immediately, IDLE, no done.
REQ-038 Saturation (CNT_W=2): 5 operands of value 1 -> count=3, acc_out=5.
